// File: rtl/pos_reader_pkg.sv
// Shared definitions for the cell position read sequencer.
package pos_reader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CNT_REQ,
    CNT_WAIT,
    STREAM,
    DRAIN,
    FINISH
  } state_t;

  localparam int RD_LATENCY = 2;
  localparam int COUNT_LSB  = 0;

endpackage

// File: rtl/pos_reader_fifo.sv
// Synchronous skid FIFO holding {addr, data} entries for the read sequencer.
module pos_reader_fifo #(
  parameter  int WIDTH = 104,
  parameter  int DEPTH = 4,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;

  // Storage is cleared on reset so the head reads zero while empty after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_i, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push_i && full_o && !pop_i));

endmodule

// File: rtl/pos_cell_reader.sv
// Reads the particle count from a cell position RAM, then streams every record downstream.
// Optional POS_READER_CNT_CHECK_EN: clamp oversize counts and report them on cnt_err.
module pos_cell_reader
  import pos_reader_pkg::*;
#(
  parameter int DATA_WIDTH   = 96,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] cell_rd_addr,
  output logic                  cell_rd_en,
  output logic                  cell_wr_en,
  input  logic [DATA_WIDTH-1:0] cell_rd_data,
  output logic [DATA_WIDTH-1:0] pos_out,
  output logic                  pos_valid,
  input  logic                  pos_ready,
  output logic                  pos_last,
  output logic [ADDR_WIDTH-1:0] particle_id,
`ifdef POS_READER_CNT_CHECK_EN
  output logic                  cnt_err,
`endif
  output logic [ADDR_WIDTH-1:0] particle_cnt
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int FW = ADDR_WIDTH + DATA_WIDTH;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]            wait_q, wait_d;
  logic [RD_LATENCY-1:0] infl_v_q;
  logic [ADDR_WIDTH-1:0] infl_a_q [RD_LATENCY];
  logic                  issue;

  logic [CW-1:0]         fifo_count;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic [FW-1:0]         fifo_rdata;
  logic [ADDR_WIDTH-1:0] head_id;
  logic [CW:0]           credit_used;
  logic                  credit_ok;
  logic [ADDR_WIDTH-1:0] cnt_raw;
  logic [ADDR_WIDTH-1:0] cnt_sel;

  assign cnt_raw = cell_rd_data[COUNT_LSB +: ADDR_WIDTH];

`ifdef POS_READER_CNT_CHECK_EN
  localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);
  logic cnt_over;
  logic cnt_err_q;

  assign cnt_over = (cnt_raw > MAX_CNT);
  assign cnt_sel  = cnt_over ? MAX_CNT : cnt_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          cnt_err_q <= 1'b0;
    else if (state_q == IDLE && start)                cnt_err_q <= 1'b0;
    else if (state_q == CNT_WAIT && wait_q == '0 && cnt_over) cnt_err_q <= 1'b1;
  end

  assign cnt_err = cnt_err_q;
`else
  assign cnt_sel = cnt_raw;
`endif

  // Outstanding reads plus buffered records never exceed the FIFO depth, so every return has a slot.
  assign credit_used = {1'b0, fifo_count} + (CW + 1)'($countones(infl_v_q));
  assign credit_ok   = (credit_used < (CW + 1)'(FIFO_DEPTH));
  assign fifo_pop    = !fifo_empty && pos_ready;

  always_comb begin
    state_d      = state_q;
    next_addr_d  = next_addr_q;
    cnt_d        = cnt_q;
    wait_d       = wait_q;
    cell_rd_en   = 1'b0;
    cell_rd_addr = '0;
    issue        = 1'b0;
    done         = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = CNT_REQ;
      end
      CNT_REQ: begin
        cell_rd_en = 1'b1;
        wait_d     = 2'(RD_LATENCY - 1);
        state_d    = CNT_WAIT;
      end
      CNT_WAIT: begin
        if (wait_q == '0) begin
          cnt_d       = cnt_sel;
          next_addr_d = ADDR_WIDTH'(1);
          state_d     = (cnt_sel == '0) ? FINISH : STREAM;
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end
      STREAM: begin
        if (credit_ok) begin
          cell_rd_en   = 1'b1;
          cell_rd_addr = next_addr_q;
          issue        = 1'b1;
          next_addr_d  = next_addr_q + ADDR_WIDTH'(1);
          if (next_addr_q == cnt_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Leave as the last record handshakes so done lands the following cycle.
        if (infl_v_q == '0 && (fifo_empty || (fifo_count == CW'(1) && fifo_pop)))
          state_d = FINISH;
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      next_addr_q <= '0;
      cnt_q       <= '0;
      wait_q      <= '0;
      infl_v_q    <= '0;
      for (int i = 0; i < RD_LATENCY; i++) infl_a_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      next_addr_q <= next_addr_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      infl_v_q    <= {infl_v_q[RD_LATENCY-2:0], issue};
      infl_a_q[0] <= cell_rd_addr;
      for (int i = 1; i < RD_LATENCY; i++) infl_a_q[i] <= infl_a_q[i-1];
    end
  end

  pos_reader_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (infl_v_q[RD_LATENCY-1]),
    .wdata_i ({infl_a_q[RD_LATENCY-1], cell_rd_data}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (),
    .empty_o (fifo_empty)
  );

  assign {head_id, pos_out} = fifo_rdata;
  assign pos_valid    = !fifo_empty;
  assign particle_id  = head_id;
  assign pos_last     = pos_valid && (head_id == cnt_q);
  assign particle_cnt = cnt_q;
  assign busy         = (state_q != IDLE);
  assign cell_wr_en   = 1'b0;

endmodule

// File: tb/tb_pos_cell_reader.sv
// Scoreboard bench for pos_cell_reader: RAM model, randomized backpressure, queue-based checking.
module tb_pos_cell_reader;

  localparam int DW = 96;
  localparam int AW = 8;
  localparam int PN = 220;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done;
  logic [AW-1:0] cell_rd_addr;
  logic          cell_rd_en, cell_wr_en;
  logic [DW-1:0] cell_rd_data;
  logic [DW-1:0] pos_out;
  logic          pos_valid, pos_ready, pos_last;
  logic [AW-1:0] particle_id, particle_cnt;
`ifdef POS_READER_CNT_CHECK_EN
  logic          cnt_err;
`endif

  pos_cell_reader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .cell_rd_addr (cell_rd_addr),
    .cell_rd_en   (cell_rd_en),
    .cell_wr_en   (cell_wr_en),
    .cell_rd_data (cell_rd_data),
    .pos_out      (pos_out),
    .pos_valid    (pos_valid),
    .pos_ready    (pos_ready),
    .pos_last     (pos_last),
    .particle_id  (particle_id),
`ifdef POS_READER_CNT_CHECK_EN
    .cnt_err      (cnt_err),
`endif
    .particle_cnt (particle_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] id;
    logic          last;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          e;
  logic [DW-1:0] mem [256];
  logic [DW-1:0] rd_s1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rmode = 0;
  int ph = 0;
  int n_eff;
  int run_beats, popped, rd_stream, rd_cnt, cnt_reads, valid_cycles, done_cnt;
  int first_rd_cyc, first_beat_cyc, last_beat_cyc, done_cyc;

  logic          prev_valid = 1'b0;
  logic          prev_ready = 1'b0;
  logic [DW-1:0] prev_out;
  logic [AW-1:0] prev_id;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // RAM: 2-cycle read latency; garbage on the data bus when no read was issued.
  always @(posedge clk) begin
    rd_s1        <= cell_rd_en ? mem[cell_rd_addr] : {$urandom, $urandom, $urandom};
    cell_rd_data <= rd_s1;
  end

  initial begin
    pos_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        1:       begin pos_ready = (ph % 4 == 0) || (ph % 4 == 3); ph++; end
        2:       pos_ready = 1'($urandom_range(0, 1));
        default: pos_ready = 1'b1;
      endcase
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      chk("wr_en_zero", cell_wr_en, 1'b0);
      if (cell_rd_en) begin
        rd_cnt++;
        if (cell_rd_addr == '0) cnt_reads++;
        else begin
          chk("credit_limit", (rd_stream - popped) < 4, 1'b1);
          if (rd_stream == 0) first_rd_cyc = cyc;
          rd_stream++;
        end
      end
      if (prev_valid && !prev_ready) begin
        chk("stall_valid", pos_valid, 1'b1);
        chk("stall_data", pos_out, prev_out);
        chk("stall_id", particle_id, prev_id);
      end
      if (pos_valid) valid_cycles++;
      if (pos_valid && pos_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", particle_id, 0);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", pos_out, e.data);
          chk("beat_id", particle_id, e.id);
          chk("beat_last", pos_last, e.last);
        end
        if (run_beats == 0) first_beat_cyc = cyc;
        run_beats++;
        popped++;
        last_beat_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_valid = pos_valid;
      prev_ready = pos_ready;
      prev_out   = pos_out;
      prev_id    = particle_id;
    end
  end

  task automatic clear_run();
    run_beats = 0; popped = 0; rd_stream = 0; rd_cnt = 0; cnt_reads = 0;
    valid_cycles = 0; done_cnt = 0; first_rd_cyc = 0; first_beat_cyc = 0;
    last_beat_cyc = 0; done_cyc = 0;
    exp_q.delete();
  endtask

  task automatic load_cell(input int n, input bit fixed);
    mem[0] = {$urandom, $urandom, $urandom};
    mem[0][7:0] = n[7:0];
    n_eff = n;
`ifdef POS_READER_CNT_CHECK_EN
    if (n_eff > PN - 1) n_eff = PN - 1;
`endif
    for (int i = 1; i <= n_eff; i++) begin
      mem[i] = fixed ? 96'(32'hA0 + i) : {$urandom, $urandom, $urandom};
      exp_q.push_back('{id: AW'(i), last: (i == n_eff), data: mem[i]});
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_cell(input int n, input bit fixed, input int mode, input bit extra_start);
    int k;
    clear_run();
    load_cell(n, fixed);
    rmode = mode;
    pulse_start();
    chk("busy_after_start", busy, 1'b1);
    for (k = 0; k < 5000; k++) begin
      @(posedge clk); #1;
      if (done_cnt > 0) break;
      start = extra_start && busy && (k == 8 || k == 12);
    end
    start = 1'b0;
    if (k >= 5000) chk("done_timeout", 1'b0, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk("done_count", done_cnt, 1);
    chk("beat_count", run_beats, n_eff);
    chk("queue_empty", exp_q.size(), 0);
    chk("busy_after_done", busy, 1'b0);
    chk("count_reads", cnt_reads, 1);
    chk("total_reads", rd_cnt, n_eff + 1);
    chk("particle_cnt", particle_cnt, n_eff);
    if (n_eff == 0) chk("no_valid_zero", valid_cycles, 0);
    else begin
      chk("done_after_last", done_cyc - last_beat_cyc, 1);
      if (mode == 0) begin
        chk("first_latency", first_beat_cyc - first_rd_cyc, 3);
        chk("back_to_back", last_beat_cyc - first_beat_cyc, n_eff - 1);
      end
    end
  endtask

  task automatic reset_mid_stream();
    int k;
    clear_run();
    load_cell(10, 1'b0);
    rmode = 0;
    pulse_start();
    for (k = 0; k < 200; k++) begin
      @(negedge clk); #1;
      if (run_beats >= 3) break;
    end
    chk("abort_reached", run_beats >= 3, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_valid", pos_valid, 1'b0);
    chk("rst_rd_en", cell_rd_en, 1'b0);
    chk("rst_pos_out", pos_out, '0);
    chk("rst_id", particle_id, '0);
    chk("rst_cnt", particle_cnt, '0);
    chk("rst_last", pos_last, 1'b0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    #1;
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_valid", pos_valid, 1'b0);
    chk("reset_rd_en", cell_rd_en, 1'b0);
    chk("reset_cnt", particle_cnt, '0);
    chk("reset_last", pos_last, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    run_cell(5, 1'b1, 0, 1'b0);
    run_cell(0, 1'b0, 0, 1'b0);
    run_cell(8, 1'b0, 1, 1'b0);
    run_cell(6, 1'b0, 0, 1'b1);
    reset_mid_stream();
    run_cell(2, 1'b0, 0, 1'b0);
    run_cell(1, 1'b0, 0, 1'b0);
    run_cell(219, 1'b0, 2, 1'b0);
    for (int t = 0; t < 6; t++) run_cell(int'($urandom_range(1, 30)), 1'b0, 2, 1'b0);
`ifdef POS_READER_CNT_CHECK_EN
    run_cell(250, 1'b0, 0, 1'b0);
    chk("cnt_err_set", cnt_err, 1'b1);
    run_cell(3, 1'b0, 1, 1'b0);
    chk("cnt_err_clear", cnt_err, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
